// File: rtl/sys_pio_pkg.sv
// Shared constants for the PIO input block: register addresses and edge selection.
package sys_pio_pkg;

  typedef enum logic [1:0] {
    EDGE_RISING  = 2'd0,
    EDGE_FALLING = 2'd1,
    EDGE_ANY     = 2'd2
  } edge_type_e;

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
  localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;

endpackage

// File: rtl/sys_pio_sync.sv
// Multi-flop synchronizer for a bus of independent asynchronous bits.
// Each bit is synchronized on its own; no cross-bit coherency is implied.
module sys_pio_sync #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [STAGES];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/sys_pio_in.sv
// Avalon-MM parallel input port with per-bit edge capture and masked level interrupt.
// Reads return one cycle after the request; edges reach EDGE_CAPTURE SYNC_STAGES+1 cycles after sampling.
module sys_pio_in
  import sys_pio_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter edge_type_e  EDGE_TYPE   = EDGE_RISING,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] sync_in;
  logic [WIDTH-1:0] sync_d_q;
  logic [WIDTH-1:0] edge_detect;
  logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
  logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             wr_stb, rd_stb;

  sys_pio_sync #(
    .WIDTH  (WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (in_port),
    .q_o     (sync_in)
  );

  assign wr_stb = chipselect && !write_n;
  assign rd_stb = chipselect && write_n;

  always_comb begin
    edge_detect = '0;
    case (EDGE_TYPE)
      EDGE_RISING:  edge_detect = sync_in & ~sync_d_q;
      EDGE_FALLING: edge_detect = ~sync_in & sync_d_q;
      EDGE_ANY:     edge_detect = sync_in ^ sync_d_q;
      default:      edge_detect = '0;
    endcase
  end

  always_comb begin
    edge_cap_d = edge_cap_q;
    irq_mask_d = irq_mask_q;
    readdata_d = '0;
    if (wr_stb && address == ADDR_EDGE_CAP) edge_cap_d = edge_cap_q & ~writedata[WIDTH-1:0];
    // New edges are ORed in after the clear so a coincident edge is never lost.
    edge_cap_d = edge_cap_d | edge_detect;
    if (wr_stb && address == ADDR_IRQ_MASK) irq_mask_d = writedata[WIDTH-1:0];
    if (rd_stb) begin
      case (address)
        ADDR_DATA:     readdata_d = 32'(sync_in);
        ADDR_IRQ_MASK: readdata_d = 32'(irq_mask_q);
        ADDR_EDGE_CAP: readdata_d = 32'(edge_cap_q);
        default:       readdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_d_q   <= '0;
      edge_cap_q <= '0;
      irq_mask_q <= '0;
      readdata_q <= '0;
    end else begin
      sync_d_q   <= sync_in;
      edge_cap_q <= edge_cap_d;
      irq_mask_q <= irq_mask_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(edge_cap_q & irq_mask_q);

endmodule

// File: doc/sys_pio_in.md
SYS_PIO_IN -- requirements
Module: sys_pio_in

Interface
REQ-001 Parameter WIDTH, default 32: number of input port bits, 1..32.
REQ-002 Parameter EDGE_TYPE, default EDGE_RISING: edge that sets a capture bit, one of EDGE_RISING, EDGE_FALLING or EDGE_ANY.
REQ-003 Parameter SYNC_STAGES, default 2: number of synchronizer flops per input bit, 2..3.
REQ-004 clk  input  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 address  input  3  Avalon-MM word address.
REQ-007 chipselect  input  1  slave select.
REQ-008 write_n  input  1  active-low write strobe.
REQ-009 writedata  input  32  write data.
REQ-010 readdata  output  32  registered read data.
REQ-011 in_port  input  WIDTH  asynchronous external inputs.
REQ-012 irq  output  1  level interrupt, active high.

Function
REQ-013 Register map SHALL be:
- 0 = DATA (read-only, synchronized inputs)
- 2 = IRQ_MASK (read/write, WIDTH bits)
- 3 = EDGE_CAPTURE (read; write 1 to clear)
- all other addresses read 0 and ignore writes.
REQ-014 Each in_port bit SHALL pass through SYNC_STAGES flops; the synchronized value is sync_in.
REQ-015 A further flop SHALL hold sync_d, the previous value of sync_in.
REQ-016 edge_detect SHALL be:
- EDGE_RISING: sync_in & ~sync_d
- EDGE_FALLING: ~sync_in & sync_d
- EDGE_ANY: sync_in ^ sync_d.
REQ-017 A write strobe SHALL be chipselect && !write_n; a read SHALL be chipselect && write_n.
REQ-018 EDGE_CAPTURE bit i SHALL be set on the cycle after edge_detect[i] is 1 and SHALL stay set until cleared.
REQ-019 A write to address 3 SHALL clear each bit whose writedata bit is 1; bits whose writedata bit is 0 SHALL be unchanged.
REQ-020 If a clear of bit i and edge_detect[i] occur in the same cycle, the edge SHALL win and the bit SHALL remain 1.
REQ-021 A write to address 2 SHALL load IRQ_MASK with writedata[WIDTH-1:0] on the next edge.
REQ-022 readdata SHALL be registered, giving read latency 1: on the edge after a read, readdata = selected register, zero-extended to 32 bits.
REQ-023 When no read is in progress, readdata SHALL be 0.
REQ-024 irq SHALL be |(EDGE_CAPTURE & IRQ_MASK), computed combinationally from registered state.
REQ-025 An in_port edge SHALL reach EDGE_CAPTURE SYNC_STAGES+1 cycles after the first clk edge that samples it.
REQ-026 Reads SHALL have no side effects; reading EDGE_CAPTURE SHALL NOT clear it.
REQ-027 Bits at or above WIDTH SHALL read 0 and SHALL ignore writes.

Reset
REQ-028 Asserting reset_n low SHALL asynchronously clear the following to 0: synchronizer flops, sync_d, EDGE_CAPTURE, IRQ_MASK, readdata and irq.
REQ-029 A reset asserted mid-operation SHALL discard pending edges.
REQ-030 No edge SHALL be captured from the first sync_d load after reset release, because sync_d and sync_in both start at 0.

Structure
REQ-031 Package sys_pio_pkg SHALL hold the address constants (ADDR_DATA=0, ADDR_IRQ_MASK=2, ADDR_EDGE_CAP=3) and the EDGE_TYPE enumeration.
REQ-032 The per-bit synchronizer SHALL be a single sub-module, sys_pio_sync, parameterized by width and stage count.

Verification
REQ-033 Reset, then read address 0 with in_port=0x0000_00A5 held for 4 cycles -> readdata=0x0000_00A5 one cycle after the read; irq=0.
REQ-034 EDGE_RISING, IRQ_MASK=0x1; raise in_port[0] -> EDGE_CAPTURE=0x1 after 3 cycles, irq=1; write 0x1 to address 3 -> irq=0 next cycle.
REQ-035 IRQ_MASK=0; toggle in_port[4] -> EDGE_CAPTURE=0x10 and irq stays 0; then write IRQ_MASK=0x10 -> irq=1 next cycle.
REQ-036 Write 0x1 to address 3 in the same cycle edge_detect[0]=1 -> EDGE_CAPTURE[0] stays 1.
REQ-037 EDGE_ANY, IRQ_MASK=0xFFFF_FFFF; pulse in_port[31] high for 5 cycles then low -> bit 31 captured; assert reset_n low mid-pulse -> all registers, readdata and irq read 0 immediately.
